// File: rtl/ics2115_sample_fetch.sv
// ICS2115 sample-memory fetch scheduler: round-robin arbitration of per-voice
// 64-bit word reads onto the single shared SDRAM read port.
module ics2115_sample_fetch #(
    parameter int          VOICES    = 32,
    parameter logic [28:0] BASE_ADDR = 29'h0800000,
    parameter int          TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [VOICES-1:0]    voice_req,
    input  logic [VOICES*21-1:0] voice_addr,
    output logic [VOICES-1:0]    voice_ack,
    output logic                 fetch_valid,
    output logic [63:0]          fetch_data,
    output logic [4:0]           fetch_voice,
    output logic                 fetch_err,
    output logic                 sdram_rd,
    output logic [28:0]          sdram_addr,
    input  logic [63:0]          sdram_dout,
    input  logic                 sdram_busy,
    input  logic                 sdram_dout_ready,
    output logic                 busy
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] WAIT    = 2'd2;
    localparam logic [1:0] DELIVER = 2'd3;

    localparam logic [5:0]        NV      = 6'(VOICES);
    localparam logic [9:0]        TO      = 10'(TIMEOUT);
    localparam logic [VOICES-1:0] ACK_ONE = VOICES'(1);

    logic [1:0]        state_q, state_d;
    logic [4:0]        last_grant_q, last_grant_d;
    logic [4:0]        cur_voice_q, cur_voice_d;
    logic [9:0]        cnt_q, cnt_d;
    logic              sdram_rd_q, sdram_rd_d;
    logic [28:0]       sdram_addr_q, sdram_addr_d;
    logic [VOICES-1:0] voice_ack_q, voice_ack_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [63:0]       fetch_data_q, fetch_data_d;
    logic [4:0]        fetch_voice_q, fetch_voice_d;
    logic              fetch_err_q, fetch_err_d;
    logic              busy_q, busy_d;

    logic [63:0] req_ext;
    logic [20:0] addr_arr [64];
    logic [5:0]  cand;
    logic [5:0]  grant_idx;
    logic        grant_found;
    logic [28:0] grant_byte;

    // Pad requests and addresses to 64 slots so a 6-bit index never runs off the end.
    assign req_ext = 64'(voice_req);

    for (genvar v = 0; v < 64; v++) begin : g_addr
        if (v < VOICES) begin : g_on
            assign addr_arr[v] = voice_addr[v*21 +: 21];
        end else begin : g_off
            assign addr_arr[v] = '0;
        end
    end

    // Descending scan so the nearest requester after last_grant wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = VOICES; i >= 1; i--) begin
            cand = {1'b0, last_grant_q} + 6'(i);
            if (cand >= NV) begin
                cand = cand - NV;
            end
            if (req_ext[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant_byte = BASE_ADDR + {5'b0, addr_arr[grant_idx], 3'b000};

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        cur_voice_d   = cur_voice_q;
        cnt_d         = cnt_q;
        sdram_rd_d    = sdram_rd_q;
        sdram_addr_d  = sdram_addr_q;
        voice_ack_d   = '0;
        fetch_valid_d = 1'b0;
        fetch_data_d  = fetch_data_q;
        fetch_voice_d = fetch_voice_q;
        fetch_err_d   = fetch_err_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    state_d      = ISSUE;
                    last_grant_d = grant_idx[4:0];
                    cur_voice_d  = grant_idx[4:0];
                    sdram_rd_d   = 1'b1;
                    sdram_addr_d = grant_byte;
                end
            end
            ISSUE: begin
                if (!sdram_busy) begin
                    state_d    = WAIT;
                    sdram_rd_d = 1'b0;
                    cnt_d      = '0;
                end
            end
            WAIT: begin
                // Data arriving on the timeout cycle still counts as a good read.
                if (sdram_dout_ready || (cnt_q + 10'd1 == TO)) begin
                    state_d       = DELIVER;
                    fetch_valid_d = 1'b1;
                    voice_ack_d   = ACK_ONE << cur_voice_q;
                    fetch_voice_d = cur_voice_q;
                    fetch_err_d   = !sdram_dout_ready;
                    fetch_data_d  = sdram_dout_ready ? sdram_dout : 64'd0;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            last_grant_q  <= '0;
            cur_voice_q   <= '0;
            cnt_q         <= '0;
            sdram_rd_q    <= 1'b0;
            sdram_addr_q  <= '0;
            voice_ack_q   <= '0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
            fetch_voice_q <= '0;
            fetch_err_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            cur_voice_q   <= cur_voice_d;
            cnt_q         <= cnt_d;
            sdram_rd_q    <= sdram_rd_d;
            sdram_addr_q  <= sdram_addr_d;
            voice_ack_q   <= voice_ack_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_data_q  <= fetch_data_d;
            fetch_voice_q <= fetch_voice_d;
            fetch_err_q   <= fetch_err_d;
            busy_q        <= busy_d;
        end
    end

    assign sdram_rd    = sdram_rd_q;
    assign sdram_addr  = sdram_addr_q;
    assign voice_ack   = voice_ack_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_data  = fetch_data_q;
    assign fetch_voice = fetch_voice_q;
    assign fetch_err   = fetch_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ics2115_sample_fetch.sv
// Bench for ics2115_sample_fetch: directed scenarios plus randomized traffic,
// with a round-robin reference model feeding a scoreboard checked by a monitor.
module tb_ics2115_sample_fetch;
    localparam int          NV   = 32;
    localparam int          TO   = 4;
    localparam logic [28:0] BASE = 29'h0800000;

    typedef struct {
        int          voice;
        logic [63:0] data;
        logic        err;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [NV-1:0]     voice_req = '0;
    logic [NV*21-1:0]  voice_addr = '0;
    logic [NV-1:0]     voice_ack;
    logic              fetch_valid;
    logic [63:0]       fetch_data;
    logic [4:0]        fetch_voice;
    logic              fetch_err;
    logic              sdram_rd;
    logic [28:0]       sdram_addr;
    logic [63:0]       sdram_dout = '0;
    logic              sdram_busy = 1'b0;
    logic              sdram_dout_ready = 1'b0;
    logic              busy;

    logic [1:0]  w_req = '0;
    logic [41:0] w_vaddr = '0;
    logic [1:0]  w_ack;
    logic        w_fv;
    logic [63:0] w_fd;
    logic [4:0]  w_fvoice;
    logic        w_ferr;
    logic        w_rd;
    logic [28:0] w_saddr;
    logic [63:0] w_dout = '0;
    logic        w_ready = 1'b0;
    logic        w_busy_o;

    int n_checks = 0;
    int n_errors = 0;
    exp_t sb[$];
    int model_last = 0;
    logic [NV-1:0] req_seen = '0;
    int cfg_busy = -1;
    int cfg_p = -1;
    logic cfg_fixed = 1'b0;
    logic [63:0] cfg_data = '0;

    ics2115_sample_fetch #(.VOICES(NV), .BASE_ADDR(BASE), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .voice_req(voice_req), .voice_addr(voice_addr),
        .voice_ack(voice_ack), .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .fetch_voice(fetch_voice), .fetch_err(fetch_err), .sdram_rd(sdram_rd),
        .sdram_addr(sdram_addr), .sdram_dout(sdram_dout), .sdram_busy(sdram_busy),
        .sdram_dout_ready(sdram_dout_ready), .busy(busy)
    );

    ics2115_sample_fetch #(.VOICES(2), .BASE_ADDR(29'h1FFFFFF8), .TIMEOUT(255)) u_wrap (
        .clk(clk), .reset_n(reset_n), .voice_req(w_req), .voice_addr(w_vaddr),
        .voice_ack(w_ack), .fetch_valid(w_fv), .fetch_data(w_fd),
        .fetch_voice(w_fvoice), .fetch_err(w_ferr), .sdram_rd(w_rd),
        .sdram_addr(w_saddr), .sdram_dout(w_dout), .sdram_busy(1'b0),
        .sdram_dout_ready(w_ready), .busy(w_busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) req_seen <= voice_req;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // First requesting voice after 'last', ascending with wrap; -1 if none.
    function automatic int rr(input int last, input logic [NV-1:0] req);
        for (int i = 1; i <= NV; i++) begin
            if (req[(last + i) % NV]) return (last + i) % NV;
        end
        return -1;
    endfunction

    function automatic logic [28:0] exp_addr(input int v);
        longint a;
        a = (longint'(BASE) + longint'(voice_addr[v*21 +: 21]) * 8) % (longint'(1) << 29);
        return a[28:0];
    endfunction

    // SDRAM responder: backpressure, then a ready pulse at WAIT position p (p > TO means none in time).
    initial begin : responder
        int b, p, v;
        logic [63:0] d;
        logic [28:0] a;
        exp_t e;
        forever begin
            if (reset_n === 1'b1 && sdram_rd === 1'b1) begin
                v = rr(model_last, req_seen);
                check_eq("issue_has_request", (v >= 0), 1);
                if (v < 0) v = 0;
                model_last = v;
                a = exp_addr(v);
                check_eq("sdram_addr", sdram_addr, a);
                check_eq("busy_issue", busy, 1);
                b = (cfg_busy >= 0) ? cfg_busy : int'($urandom_range(0, 3));
                p = (cfg_p >= 0) ? cfg_p : int'($urandom_range(1, 6));
                d = cfg_fixed ? cfg_data : {$urandom, $urandom};
                e.voice = v;
                e.err   = (p > TO);
                e.data  = (p > TO) ? 64'd0 : d;
                sb.push_back(e);
                for (int i = 0; i < b; i++) begin
                    sdram_busy = 1'b1;
                    @(negedge clk);
                    check_eq("rd_held", sdram_rd, 1);
                    check_eq("addr_stable", sdram_addr, a);
                end
                sdram_busy = 1'b0;
                @(negedge clk);
                check_eq("rd_dropped", sdram_rd, 0);
                for (int k = 1; k <= p; k++) begin
                    sdram_dout_ready = (k == p);
                    sdram_dout = (k == p) ? d : {$urandom, $urandom};
                    @(negedge clk);
                end
                sdram_dout_ready = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1) begin
                if (fetch_valid === 1'b1) begin
                    if (sb.size() == 0) begin
                        check_eq("unexpected_fetch", fetch_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        check_eq("fetch_voice", fetch_voice, e.voice);
                        check_eq("fetch_data", fetch_data, e.data);
                        check_eq("fetch_err", fetch_err, e.err);
                        check_eq("voice_ack", voice_ack, 32'd1 << e.voice);
                        check_eq("busy_deliver", busy, 1);
                    end
                end else if (voice_ack !== '0) begin
                    check_eq("ack_without_valid", voice_ack, 0);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_rd"}, sdram_rd, 0);
        check_eq({tag, "_addr"}, sdram_addr, 0);
        check_eq({tag, "_ack"}, voice_ack, 0);
        check_eq({tag, "_valid"}, fetch_valid, 0);
        check_eq({tag, "_data"}, fetch_data, 0);
        check_eq({tag, "_voice"}, fetch_voice, 0);
        check_eq({tag, "_err"}, fetch_err, 0);
        check_eq({tag, "_busy"}, busy, 0);
    endtask

    task automatic req_one(input int v, input logic [20:0] a, input int bsy, input int p,
                           input logic [63:0] d, output int lat, output int rdc);
        voice_addr[v*21 +: 21] = a;
        cfg_busy = bsy; cfg_p = p; cfg_data = d; cfg_fixed = 1'b1;
        voice_req[v] = 1'b1;
        lat = 0; rdc = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (sdram_rd) rdc++;
            if (fetch_valid) break;
        end
        voice_req[v] = 1'b0;
    endtask

    // Collect n deliveries; hold=1 keeps requests up until the last one.
    task automatic serve_n(input int n, input bit hold, output int order[$]);
        int cyc;
        cyc = 0;
        order = {};
        while (order.size() < n && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (fetch_valid) begin
                order.push_back(int'(fetch_voice));
                if (!hold || order.size() == n) voice_req = hold ? '0 : (voice_req & ~voice_ack);
            end
        end
        check_eq("serve_count", order.size(), n);
    endtask

    initial begin : main
        int lat, rdc, cnt;
        int order[$];
        bit cool[NV];
        bit en;
        int exp_rr[4] = '{3, 31, 0, 3};

        voice_addr[0*21 +: 21]  = 21'h000100;
        voice_addr[3*21 +: 21]  = 21'h000203;
        voice_addr[31*21 +: 21] = 21'h1FFFFF;
        voice_req = (32'd1 << 0) | (32'd1 << 3) | (32'd1 << 31);
        cfg_busy = 0; cfg_p = 1; cfg_fixed = 1'b0;
        #1 reset_n = 1'b0;
        @(negedge clk);
        #1 check_outputs_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        serve_n(4, 1'b1, order);
        for (int i = 0; i < 4; i++) check_eq("rr_order", (i < order.size()) ? order[i] : -1, exp_rr[i]);
        repeat (3) @(negedge clk);

        req_one(5, 21'h000010, 0, 1, 64'hDEADBEEF_01234567, lat, rdc);
        check_eq("single_latency", lat, 3);
        check_eq("single_data", fetch_data, 64'hDEADBEEF_01234567);
        check_eq("single_addr", sdram_addr, 29'h0800080);
        repeat (3) @(negedge clk);

        req_one(7, 21'h0ABCDE, 6, 2, 64'h1111_2222_3333_4444, lat, rdc);
        check_eq("bp_rd_cycles", rdc, 7);
        check_eq("bp_latency", lat, 10);
        repeat (3) @(negedge clk);

        req_one(9, 21'h000777, 0, 6, 64'hAAAA_5555_AAAA_5555, lat, rdc);
        check_eq("timeout_latency", lat, 6);
        check_eq("timeout_err", fetch_err, 1);
        check_eq("timeout_data", fetch_data, 0);
        cnt = 0;
        repeat (6) begin @(negedge clk); if (fetch_valid) cnt++; end
        check_eq("late_ready_ignored", cnt, 0);

        req_one(12, 21'h012345, 1, 4, 64'hCAFE_F00D_0000_0001, lat, rdc);
        check_eq("data_wins_latency", lat, 7);
        check_eq("data_wins_err", fetch_err, 0);
        repeat (3) @(negedge clk);

        cfg_busy = 0; cfg_p = 6; cfg_fixed = 1'b1; cfg_data = 64'h5;
        voice_addr[20*21 +: 21] = 21'h000040;
        voice_req[20] = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_outputs_zero("reset_mid_wait");
        sb.delete();
        model_last = 0;
        voice_req = '0;
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        repeat (8) begin @(negedge clk); if (voice_ack !== '0) cnt++; end
        check_eq("no_ack_after_reset", cnt, 0);
        cfg_p = 1;
        voice_addr[2*21 +: 21] = 21'h000002;
        voice_req = (32'd1 << 0) | (32'd1 << 2);
        serve_n(2, 1'b0, order);
        check_eq("post_reset_first", (order.size() > 0) ? order[0] : -1, 2);
        check_eq("post_reset_second", (order.size() > 1) ? order[1] : -1, 0);
        repeat (4) @(negedge clk);

        cfg_busy = -1; cfg_p = -1; cfg_fixed = 1'b0;
        en = 1'b1;
        for (int v = 0; v < NV; v++) cool[v] = 1'b0;
        cnt = 0;
        while (cnt < 3000) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1500) en = 1'b0;
            for (int v = 0; v < NV; v++) begin
                if (voice_ack[v]) begin
                    voice_req[v] = 1'b0;
                    cool[v] = 1'b1;
                end else if (cool[v]) begin
                    cool[v] = 1'b0;
                end else if (en && !voice_req[v] && $urandom_range(0, 15) == 0) begin
                    voice_addr[v*21 +: 21] = 21'($urandom);
                    voice_req[v] = 1'b1;
                end
            end
            if (!en && voice_req == '0 && !busy && sb.size() == 0) break;
        end
        check_eq("random_drained_req", voice_req, 0);
        check_eq("random_drained_sb", sb.size(), 0);

        @(negedge clk);
        w_vaddr[20:0] = 21'h000002;
        w_req = 2'b01;
        @(negedge clk);
        check_eq("wrap_rd", w_rd, 1);
        check_eq("wrap_addr", w_saddr, 29'h00000008);
        @(negedge clk);
        w_ready = 1'b1;
        w_dout = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        w_ready = 1'b0;
        check_eq("wrap_valid", w_fv, 1);
        check_eq("wrap_data", w_fd, 64'h0123_4567_89AB_CDEF);
        check_eq("wrap_voice", w_fvoice, 0);
        w_req = 2'b00;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ics2115_sample_fetch.md
# ics2115_sample_fetch

Sample-memory fetch scheduler for the ICS2115 wavetable voice engine. It shares the single 64-bit SDRAM sample read port between up to 32 voice requesters. Each request supplies a word address and is served with one 64-bit word, in round-robin order. The block sits between the per-voice sample pipelines and the SDRAM controller, and owns `sdram_rd`/`sdram_addr`.

## Interface
- `VOICES`, default 32: number of requesters, range 2–32.
- `BASE_ADDR`, default 29'h0800000: SDRAM byte offset of the sample ROM region.
- `TIMEOUT`, default 255: cycles to wait for `sdram_dout_ready` before abandoning a read, range 1–1023.

Ports:
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `voice_req`  in  VOICES  per-voice level request.
- `voice_addr`  in  VOICES*21  per-voice 64-bit word address; voice v uses bits [21v+20:21v].
- `voice_ack`  out  VOICES  one-hot, one-cycle pulse: the request is complete.
- `fetch_valid`  out  1  `fetch_data`, `fetch_voice` and `fetch_err` are valid; same cycle as `voice_ack`.
- `fetch_data`  out  64  returned word.
- `fetch_voice`  out  5  index of the served voice.
- `fetch_err`  out  1  the read timed out; `fetch_data` is 0.
- `sdram_rd`  out  1  read request, held until accepted.
- `sdram_addr`  out  29  byte address, stable while `sdram_rd`=1.
- `sdram_dout`  in  64  read data.
- `sdram_busy`  in  1  controller cannot accept a request this cycle.
- `sdram_dout_ready`  in  1  one-cycle pulse: `sdram_dout` is valid.
- `busy`  out  1  state ≠ IDLE.

## Operation
- FSM states:
  - IDLE: if any `voice_req` bit is set, grant one voice and go to ISSUE; otherwise stay in IDLE.
  - ISSUE: `sdram_rd`=1. Go to WAIT on the first edge where `sdram_busy`=0.
  - WAIT: on `sdram_dout_ready`=1, capture `sdram_dout` and go to DELIVER. On timeout, go to DELIVER with the error flag set.
  - DELIVER: assert outputs for one cycle, then go to IDLE.
- Arbitration: round-robin. The search starts at `(last_grant+1) mod VOICES` and takes the first set `voice_req` bit in ascending order, wrapping. `last_grant` is 0 after reset, so the first search starts at voice 1; voice 0 is checked last.
- The granted index and its address are latched at the grant edge. `sdram_addr` = (BASE_ADDR + {8'b0, word_addr, 3'b000}) mod 2^29.
- Requester contract:
  - Hold `voice_req` and the address until `voice_ack`.
  - Dropping `voice_req` before grant withdraws the request.
  - Dropping it after grant has no effect; the ack is still delivered.
  - A requester must deassert `voice_req` in the cycle after `voice_ack`, otherwise it is treated as a new request.
- Timeout: a 10-bit counter clears on entry to WAIT and increments every WAIT cycle. When it reaches TIMEOUT without `sdram_dout_ready`, the read is abandoned: `fetch_err`=1 and `fetch_data`=0.
- `sdram_dout_ready` is ignored in IDLE, ISSUE and DELIVER. This covers stray or late pulses, including one arriving after a timeout.
- If `sdram_dout_ready` and the timeout fall in the same WAIT cycle, the data wins and `fetch_err`=0.
- Reset (asynchronous, any state):
  - FSM goes to IDLE and `last_grant` to 0.
  - All outputs go to 0: `sdram_rd`, `sdram_addr`, `voice_ack`, `fetch_valid`, `fetch_data`, `fetch_voice`, `fetch_err`, `busy`.
  - Any in-flight read is dropped without an ack.

## Timing
- All outputs are registered.
- Cycle sequence (n = cycle of the first `voice_req`, FSM in IDLE):
  - n+1: `sdram_rd`=1 with `sdram_addr` valid.
  - Accept edge: the first edge where `sdram_busy`=0 while `sdram_rd`=1. `sdram_rd` drops in the following cycle.
  - `sdram_dout_ready` in WAIT cycle k gives `fetch_valid`/`voice_ack` in cycle k+1.
- Minimum request-to-ack latency is 3 cycles: req in n, ISSUE in n+1, `sdram_dout_ready` in WAIT cycle n+2, DELIVER in n+3.
- The next grant is evaluated in the IDLE cycle after DELIVER, so back-to-back service has a throughput of at most one word per 4 cycles.
- `sdram_busy` held high keeps the FSM in ISSUE indefinitely. There is no timeout in ISSUE.
- `busy`=1 from the ISSUE cycle through the DELIVER cycle.

## Test plan
- Single request: voice 5, addr 21'h000010, `sdram_busy`=0, `sdram_dout_ready` in the first WAIT cycle with data 64'hDEADBEEF_01234567.
  - Required: `sdram_addr`=29'h0800080.
  - Required: `fetch_valid`, `voice_ack[5]`, `fetch_voice`=5 and the data appear 3 cycles after the request.
- Round-robin: voices 0, 3 and 31 held requesting from reset, each read returning immediately.
  - Required grant order: 3, 31, 0, 3, …
  - No voice is served twice while another is pending.
- Backpressure: `sdram_busy`=1 for 6 cycles after ISSUE.
  - Required: `sdram_rd` stays 1 with a constant `sdram_addr` for 7 cycles, then drops.
- Timeout: TIMEOUT=4, no `sdram_dout_ready`.
  - Required: DELIVER follows the 4th WAIT cycle with `fetch_err`=1 and `fetch_data`=0.
  - Required: a `sdram_dout_ready` pulse arriving 2 cycles later is ignored.
- Address wrap: BASE_ADDR=29'h1FFFFFF8, addr 21'h000002. Required: `sdram_addr`=29'h00000008.
- Reset mid-WAIT: assert `reset_n`=0 for one cycle.
  - Required: all outputs are 0 immediately.
  - Required: no ack for the dropped voice.
  - Required: the next grant search starts at voice 1.
